pwm_duty_meter: RTL and testbench

- Receive-side counterpart of the PWM LED driver: samples an external PWM waveform, measures period and high time in clk cycles, and reports results with a one-cycle valid strobe.
- Flags loss of signal (stuck-high/stuck-low) after a counter-limited timeout.
- Sits behind the dedicated input pins for loopback and self-test of the PWM output.

---
 rtl/pwm_duty_meter.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the period and the high time of an external PWM
// waveform in clk cycles. A one-cycle meas_valid strobe marks each completed
// period. no_signal is raised when no rising edge arrives within the counter
// range, and stuck_level then reports the level the pin is stuck at.
// Optional input glitch filter: define PWM_DEGLITCH_EN.
`timescale 1ns/1ps

module pwm_duty_meter #(
    parameter int CNT_W        = 8,
    parameter int DEGLITCH_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    logic             s1_q;
    logic             s2_q;
    logic             f;
    logic             f_d_q;
    logic             rise;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q,  hi_cnt_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic             valid_q,   valid_d;
    logic             nosig_q,   nosig_d;
    logic             stuck_q,   stuck_d;

    // Two-flop synchronizer for the asynchronous pin; runs regardless of ena.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_DEGLITCH_EN
    // The filtered level only follows s2 after it has disagreed for
    // DEGLITCH_CYC consecutive cycles, so short pulses and gaps vanish.
    localparam int FILT_W = (DEGLITCH_CYC > 1) ? $clog2(DEGLITCH_CYC) : 1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(DEGLITCH_CYC - 1);

    logic              f_q, f_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

    // Filter next state: count disagreement cycles, flip on the last one.
    always_comb begin
        f_d        = f_q;
        filt_cnt_d = '0;
        if (s2_q != f_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                f_d = s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q        <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            f_q        <= f_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign f = f_q;
`else
    // Filter disabled: the synchronizer output is the working level and the
    // window parameter has no effect.
    logic unused_deglitch_cfg;
    assign unused_deglitch_cfg = ^DEGLITCH_CYC;
    assign f = s2_q;
`endif

    assign rise = f & ~f_d_q;

    // Next-state logic: measurement counters, result capture and timeout.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        nosig_d   = nosig_q;
        stuck_d   = stuck_q;

        if (!ena) begin
            // Disabled: discard any partial period, keep reported results.
            state_d   = ST_ARM;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    // The first edge only starts a period; nothing to report.
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        nosig_d   = 1'b0;
                        state_d   = ST_MEASURE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        nosig_d = 1'b1;
                        state_d = ST_TIMEOUT;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        hi_cnt_d  = '0;
                    end
                end
                ST_MEASURE: begin
                    // A rise on the MAX cycle still closes a valid period.
                    if (rise) begin
                        period_d  = per_cnt_q;
                        high_d    = hi_cnt_q;
                        valid_d   = 1'b1;
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else if (per_cnt_q == CNT_MAX) begin
                        nosig_d = 1'b1;
                        state_d = ST_TIMEOUT;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        if (f && (hi_cnt_q != CNT_MAX)) begin
                            hi_cnt_d = hi_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_TIMEOUT: begin
                    // Track the stuck level; a rise restarts like ARM does.
                    stuck_d = f;
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        nosig_d   = 1'b0;
                        state_d   = ST_MEASURE;
                    end
                end
                default: begin
                    state_d   = ST_ARM;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARM;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            nosig_q   <= 1'b0;
            stuck_q   <= 1'b0;
            f_d_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            nosig_q   <= nosig_d;
            stuck_q   <= stuck_d;
            f_d_q     <= f;
        end
    end

    assign period_cnt  = period_q;
    assign high_cnt    = high_q;
    assign meas_valid  = valid_q;
    assign no_signal   = nosig_q;
    assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: directed stimulus for pwm_duty_meter. Every rise that
// closes a period pushes the expected period/high/strobe cycle into a
// scoreboard; a negedge monitor pops and compares on each due strobe.
`timescale 1ns/1ps

module tb_pwm_duty_meter;

    localparam int CNT_W = 8;
    localparam int DEG   = 3;
`ifdef PWM_DEGLITCH_EN
    localparam int LAT = 3 + DEG;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             no_signal;
    logic             stuck_level;

    pwm_duty_meter #(.CNT_W(CNT_W), .DEGLITCH_CYC(DEG)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .no_signal  (no_signal),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        int hi;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Monitor: on a due entry the strobe and values must match; otherwise no strobe.
    always @(negedge clk) begin
        if (sb.size() != 0 && cyc >= sb[0].due) begin
            mon_e = sb.pop_front();
            total++;
            assert (meas_valid === 1'b1) else begin
                bad++;
                $error("FAIL valid_strobe cyc=%0d got=%b want=1", cyc, meas_valid);
            end
            total++;
            assert (period_cnt === CNT_W'(mon_e.per)) else begin
                bad++;
                $error("FAIL period_cnt cyc=%0d got=%0d want=%0d", cyc, period_cnt, mon_e.per);
            end
            total++;
            assert (high_cnt === CNT_W'(mon_e.hi)) else begin
                bad++;
                $error("FAIL high_cnt cyc=%0d got=%0d want=%0d", cyc, high_cnt, mon_e.hi);
            end
            $display("meas cyc=%0d period=%0d high=%0d", cyc, period_cnt, high_cnt);
        end else begin
            total++;
            assert (meas_valid === 1'b0) else begin
                bad++;
                $error("FAIL spurious_valid cyc=%0d got=%b want=0 period=%0d high=%0d",
                       cyc, meas_valid, period_cnt, high_cnt);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One period of p cycles, high for h; gl adds a 2-cycle pulse in the low phase.
    // exp_prev: this rise closes a period of ep/eh that must be reported.
    task automatic drive_period(input int p, input int h, input bit gl,
                                input bit exp_prev, input int ep, input int eh);
        exp_t e;
        @(negedge clk);
        pwm_in = 1'b1;
        if (exp_prev) begin
            e.per = ep;
            e.hi  = eh;
            e.due = cyc + LAT;
            sb.push_back(e);
        end
        for (int i = 1; i < p; i++) begin
            @(negedge clk);
            pwm_in = (i < h) || (gl && (i == 8 || i == 9));
        end
    endtask

    task automatic run_wave(input int p, input int h, input int n);
        drive_period(p, h, 1'b0, 1'b0, 0, 0);
        for (int k = 1; k < n; k++) drive_period(p, h, 1'b0, 1'b1, p, h);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_period"}, 32'(period_cnt), 0);
        chk({tag, "_high"},   32'(high_cnt), 0);
        chk({tag, "_valid"},  32'(meas_valid), 0);
        chk({tag, "_nosig"},  32'(no_signal), 0);
        chk({tag, "_stuck"},  32'(stuck_level), 0);
    endtask

    initial begin
        int sweep[3];
        sweep[0] = 1;
        sweep[1] = 5;
        sweep[2] = 9;
        rst    = 1'b1;
        ena    = 1'b0;
        pwm_in = 1'b0;

        // Reset values.
        wait_cyc(4);
        chk_outputs_zero("reset");
        rst = 1'b0;
        ena = 1'b1;

        // Steady period 8, high 2.
        run_wave(8, 2, 6);
        wait_cyc(LAT + 4);
        chk("p8_drained", 32'(sb.size()), 0);
        ena = 1'b0;
        wait_cyc(3);
        chk("p8_hold_period", 32'(period_cnt), 8);
        chk("p8_hold_high", 32'(high_cnt), 2);
        chk("p8_nosig", 32'(no_signal), 0);

        // Duty sweep at period 10.
        for (int s = 0; s < 3; s++) begin
            ena = 1'b1;
            run_wave(10, sweep[s], 4);
            wait_cyc(LAT + 4);
            ena = 1'b0;
            wait_cyc(3);
            chk("sweep_drained", 32'(sb.size()), 0);
            chk("sweep_period", 32'(period_cnt), 10);
            chk("sweep_high", 32'(high_cnt), 32'(sweep[s]));
        end

        // Constant high: loss of signal, stuck high.
        ena = 1'b1;
        @(negedge clk);
        pwm_in = 1'b1;
        for (int i = 0; i < 400 && no_signal !== 1'b1; i++) @(negedge clk);
        chk("hi_stuck_nosig", 32'(no_signal), 1);
        wait_cyc(2);
        chk("hi_stuck_level", 32'(stuck_level), 1);
        chk("hi_stuck_period_hold", 32'(period_cnt), 10);
        chk("hi_stuck_high_hold", 32'(high_cnt), 9);

        // Timeout boundary: 255 measured, 256 times out.
        ena = 1'b0;
        pwm_in = 1'b0;
        wait_cyc(4);
        chk("ena_low_nosig_hold", 32'(no_signal), 1);
        ena = 1'b1;
        drive_period(255, 3, 1'b0, 1'b0, 0, 0);
        chk("b255_nosig_clear", 32'(no_signal), 0);
        drive_period(255, 3, 1'b0, 1'b1, 255, 3);
        drive_period(256, 3, 1'b0, 1'b1, 255, 3);
        wait_cyc(8);
        chk("b256_nosig", 32'(no_signal), 1);
        chk("b256_stuck_low", 32'(stuck_level), 0);
        chk("b256_period_hold", 32'(period_cnt), 255);
        drive_period(20, 3, 1'b0, 1'b0, 0, 0);
        chk("b_recover_nosig", 32'(no_signal), 0);
        drive_period(20, 3, 1'b0, 1'b1, 20, 3);
        wait_cyc(LAT + 4);
        ena = 1'b0;
        chk("b_drained", 32'(sb.size()), 0);

        // Stuck low from reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("rst_clear");
        wait_cyc(2);
        rst = 1'b0;
        ena = 1'b1;
        wait_cyc(250);
        chk("low_nosig_early", 32'(no_signal), 0);
        wait_cyc(12);
        chk("low_nosig", 32'(no_signal), 1);
        chk("low_stuck", 32'(stuck_level), 0);
        chk("low_period", 32'(period_cnt), 0);
        chk("low_high", 32'(high_cnt), 0);

        // Reset in the middle of a high phase of a period-12 wave.
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        run_wave(12, 6, 2);
        @(negedge clk);
        pwm_in = 1'b1;
        wait_cyc(2);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_rst");
        wait_cyc(3);
        pwm_in = 1'b0;
        wait_cyc(4);
        rst = 1'b0;
        run_wave(12, 6, 3);
        wait_cyc(LAT + 4);
        chk("mid_rst_drained", 32'(sb.size()), 0);
        chk("mid_rst_period", 32'(period_cnt), 12);
        chk("mid_rst_high", 32'(high_cnt), 6);

`ifdef PWM_DEGLITCH_EN
        // Glitches in the low phase must not create extra measurements.
        ena = 1'b0;
        wait_cyc(2);
        ena = 1'b1;
        drive_period(16, 4, 1'b1, 1'b0, 0, 0);
        for (int k = 1; k < 5; k++) drive_period(16, 4, 1'b1, 1'b1, 16, 4);
        wait_cyc(LAT + 4);
        chk("glitch_drained", 32'(sb.size()), 0);
        chk("glitch_period", 32'(period_cnt), 16);
        chk("glitch_high", 32'(high_cnt), 4);
`endif

        wait_cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
